// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex-to-segment table,
// the blank segment pattern and the digit-index width helper.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Active-high a..g codes, entry 15 (F) first down to entry 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-high seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned double
// buffering, leading-zero suppression and ghost blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic          SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic          AN_INV    = (AN_ACTIVE_LOW != 0);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          slot_end, frame_wrap;

    logic [NUM_DIGITS-1:0][3:0] pend_val, disp_val;
    logic [NUM_DIGITS-1:0]      pend_dp, pend_bm, disp_dp, disp_bm;
    logic                       pend_vld;

    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_above;
    logic                  dark, in_blank, lit;
    logic [6:0]            seg_dec;

    assign slot_end   = en && (presc == PRESC_MAX);
    assign frame_wrap = slot_end && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (!en) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load on the wrap edge bypasses pending so it lands in this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend_bm  <= '0;
            pend_vld <= 1'b0;
            disp_val <= '0;
            disp_dp  <= '0;
            disp_bm  <= '0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_bm  <= blank_mask;
            end
            if (frame_wrap) begin
                pend_vld <= 1'b0;
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_in;
                    disp_bm  <= blank_mask;
                end else if (pend_vld) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                    disp_bm  <= pend_bm;
                end
            end else if (load) begin
                pend_vld <= 1'b1;
            end
        end
    end

    // lead_zero[i]: every display digit at or above i is zero.
    always_comb begin
        zero_above = 1'b1;
        lead_zero  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (disp_val[i] == 4'h0);
            lead_zero[i] = zero_above;
        end
    end

    assign dark     = disp_bm[idx] || (lz_suppress && (idx != '0) && lead_zero[idx]);
    assign in_blank = (presc < PW'(BLANK_CYCLES));
    assign lit      = en && !in_blank && !dark;

    seg_hex_decode u_dec (
        .hex (disp_val[idx]),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_OFF ^ {7{SEG_INV}};
            dp_out     <= SEG_INV;
            an_out     <= {NUM_DIGITS{AN_INV}};
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= (lit ? seg_dec : SEG_OFF) ^ {7{SEG_INV}};
            dp_out     <= (lit && disp_dp[idx]) ^ SEG_INV;
            an_out     <= (lit ? (NUM_DIGITS'(1) << idx) : '0) ^ {NUM_DIGITS{AN_INV}};
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, monitors
// compare them against the DUT outputs.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_suppress = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    seg_scan_driver #(
        .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
        .dp_in(dp_in), .blank_mask(blank_mask), .lz_suppress(lz_suppress),
        .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t aq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input exp_t e);
        checks++;
        if (an_out !== e.an || seg_out !== e.seg || dp_out !== e.dp || frame_tick !== e.ft) begin
            errors++;
            $display("FAIL %s @%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
                     e.name, cyc, an_out, seg_out, dp_out, frame_tick, e.an, e.seg, e.dp, e.ft);
        end
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: missed sample cycle %0d (now %0d)", q[i].name, q[i].cyc, cyc);
                q.delete(i);
            end else if (q[i].cyc == cyc) begin
                cmp(q[i]);
                q.delete(i);
            end
        end
    end

    always @(negedge rst_n) begin : amon
        exp_t e;
        #1;
        if (aq.size() > 0) begin
            e = aq.pop_front();
            cmp(e);
        end
    end

    task automatic expect_at(input int c, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp, input logic ft, input string name);
        exp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.dp = dp; e.ft = ft; e.name = name;
        q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bm);
        value = v; dp_in = dp; blank_mask = bm; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    localparam logic [6:0] OFF = 7'b0000000;

    int c0, r0, guard;

    initial begin
        @(negedge clk);
        expect_at(2, 4'b1111, OFF, 1'b0, 1'b0, "reset_state");
        goto(3);
        rst_n = 1'b1;
        goto(4);
        en = 1'b1;
        c0 = cyc;

        // Scan timing and frame ticks with the reset display (all zeros)
        expect_at(c0 + 1,  4'b1111, OFF,        1'b0, 1'b0, "first_blank");
        expect_at(c0 + 2,  4'b1110, 7'b1111110, 1'b0, 1'b0, "first_digit0");
        expect_at(c0 + 15, 4'b0111, 7'b1111110, 1'b0, 1'b0, "pre_tick");
        expect_at(c0 + 16, 4'b0111, 7'b1111110, 1'b0, 1'b1, "tick1");
        expect_at(c0 + 17, 4'b1111, OFF,        1'b0, 1'b0, "post_tick");
        expect_at(c0 + 32, 4'b0111, 7'b1111110, 1'b0, 1'b1, "tick2");

        // 1234 loaded mid-frame, shown from the frame starting at c0+32
        goto(c0 + 20);
        do_load(16'h1234, 4'b0000, 4'b0000);
        expect_at(c0 + 30, 4'b0111, 7'b1111110, 1'b0, 1'b0, "old_until_commit");
        expect_at(c0 + 33, 4'b1111, OFF,        1'b0, 1'b0, "1234_blank0");
        expect_at(c0 + 34, 4'b1110, 7'b0110011, 1'b0, 1'b0, "1234_d0");
        expect_at(c0 + 37, 4'b1111, OFF,        1'b0, 1'b0, "1234_blank1");
        expect_at(c0 + 38, 4'b1101, 7'b1111001, 1'b0, 1'b0, "1234_d1");
        expect_at(c0 + 45, 4'b1111, OFF,        1'b0, 1'b0, "1234_blank3");
        expect_at(c0 + 46, 4'b0111, 7'b0110000, 1'b0, 1'b0, "1234_d3");

        // ABCD with decimal point on digit 1
        goto(c0 + 40);
        do_load(16'hABCD, 4'b0010, 4'b0000);
        expect_at(c0 + 50, 4'b1110, 7'b0111101, 1'b0, 1'b0, "abcd_d");
        expect_at(c0 + 54, 4'b1101, 7'b1001110, 1'b1, 1'b0, "abcd_C_dp");
        expect_at(c0 + 58, 4'b1011, 7'b0011111, 1'b0, 1'b0, "abcd_b");
        expect_at(c0 + 62, 4'b0111, 7'b1110111, 1'b0, 1'b0, "abcd_A");

        // Leading-zero suppression on 0050
        goto(c0 + 56);
        do_load(16'h0050, 4'b0000, 4'b0000);
        expect_at(c0 + 66, 4'b1110, 7'b1111110, 1'b0, 1'b0, "lz50_d0");
        expect_at(c0 + 70, 4'b1101, 7'b1011011, 1'b0, 1'b0, "lz50_d1");
        expect_at(c0 + 74, 4'b1111, OFF,        1'b0, 1'b0, "lz50_d2_dark");
        expect_at(c0 + 78, 4'b1111, OFF,        1'b0, 1'b0, "lz50_d3_dark");
        expect_at(c0 + 79, 4'b1111, OFF,        1'b0, 1'b0, "lz50_d3_dark_end");
        goto(c0 + 62);
        lz_suppress = 1'b1;

        // All-zero value: only digit 0 lights
        goto(c0 + 72);
        do_load(16'h0000, 4'b0000, 4'b0000);
        expect_at(c0 + 82, 4'b1110, 7'b1111110, 1'b0, 1'b0, "lz0_d0");
        expect_at(c0 + 86, 4'b1111, OFF,        1'b0, 1'b0, "lz0_d1_dark");
        expect_at(c0 + 94, 4'b1111, OFF,        1'b0, 1'b0, "lz0_d3_dark");
        goto(c0 + 95);
        lz_suppress = 1'b0;

        // Two mid-frame loads: last wins, current frame untouched
        goto(c0 + 96);
        expect_at(c0 + 110, 4'b0111, 7'b1111110, 1'b0, 1'b0, "midload_unchanged");
        expect_at(c0 + 114, 4'b1110, 7'b1101101, 1'b0, 1'b0, "2222_d0");
        expect_at(c0 + 118, 4'b1101, 7'b1101101, 1'b0, 1'b0, "2222_d1");
        expect_at(c0 + 122, 4'b1111, OFF,        1'b0, 1'b0, "2222_d2_masked");
        expect_at(c0 + 126, 4'b0111, 7'b1101101, 1'b0, 1'b0, "2222_d3");
        goto(c0 + 100);
        do_load(16'h1111, 4'b0000, 4'b0000);
        goto(c0 + 104);
        do_load(16'h2222, 4'b0000, 4'b0100);

        // Load coinciding with the commit edge at c0+128
        goto(c0 + 127);
        expect_at(c0 + 128, 4'b0111, 7'b1101101, 1'b0, 1'b1, "edge_old_display");
        expect_at(c0 + 130, 4'b1110, 7'b1111111, 1'b0, 1'b0, "edge_5678_d0");
        expect_at(c0 + 142, 4'b0111, 7'b1011011, 1'b0, 1'b0, "edge_5678_d3");
        do_load(16'h5678, 4'b0000, 4'b0000);

        // Asynchronous reset between clock edges
        goto(c0 + 150);
        begin
            exp_t e;
            e.cyc = 0; e.an = 4'b1111; e.seg = OFF; e.dp = 1'b0; e.ft = 1'b0; e.name = "async_reset";
            aq.push_back(e);
        end
        expect_at(c0 + 151, 4'b1111, OFF, 1'b0, 1'b0, "in_reset");
        #2 rst_n = 1'b0;
        goto(c0 + 152);
        rst_n = 1'b1;
        r0 = cyc;
        expect_at(r0 + 1,  4'b1111, OFF,        1'b0, 1'b0, "restart_blank");
        expect_at(r0 + 2,  4'b1110, 7'b1111110, 1'b0, 1'b0, "restart_d0_zero");
        expect_at(r0 + 16, 4'b0111, 7'b1111110, 1'b0, 1'b1, "restart_tick");
        expect_at(r0 + 17, 4'b1111, OFF,        1'b0, 1'b0, "restart_post_tick");

        goto(r0 + 18);
        guard = 0;
        while ((q.size() > 0 || aq.size() > 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0 || aq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never sampled, want 0", q.size() + aq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
